// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: micro-op layout, ROB index/pointer types and state encoding.
package reorder_buffer_pkg;

  localparam int ROB_SIZE       = 64;
  localparam int RENAME_WIDTH   = 4;
  localparam int COMMIT_WIDTH   = 4;
  localparam int COMPLETE_WIDTH = 4;
  localparam int ROB_INDEX_SIZE = $clog2(ROB_SIZE);
  localparam int ARF_INT_SIZE   = 32;
  localparam int PRF_INT_SIZE   = 64;
  localparam int CP_SIZE        = 8;
  localparam int CNT_W          = $clog2(COMMIT_WIDTH + 1);
  localparam int LANE_W         = $clog2(COMMIT_WIDTH);

  typedef logic [ROB_INDEX_SIZE-1:0] rob_index_t;
  // Pointer carries one extra wrap bit so full and empty are distinguishable
  typedef logic [ROB_INDEX_SIZE:0]   rob_ptr_t;

  typedef enum logic {ROB_NORMAL, ROB_RECOVER} rob_state_t;

  typedef struct packed {
    logic                            valid;
    logic                            rd_valid;
    logic [$clog2(ARF_INT_SIZE)-1:0] rd_arf_int_index;
    logic [$clog2(PRF_INT_SIZE)-1:0] rd_prf_int_index;
    logic [$clog2(PRF_INT_SIZE)-1:0] rd_prev_prf_int_index;
    logic                            is_branch;
    logic [$clog2(CP_SIZE)-1:0]      cp_index;
    rob_index_t                      rob_index;
  } micro_op_t;

  function automatic rob_index_t rob_add(rob_index_t base, int off);
    return base + rob_index_t'(off);
  endfunction

endpackage

// File: rtl/reorder_buffer_retire_select.sv
// Combinational retire picker: longest in-order run of done entries from head, cut after a mispredicted branch.
module rob_retire_select
  import reorder_buffer_pkg::*;
(
  input  rob_index_t          head,
  input  logic [ROB_SIZE-1:0] valid,
  input  logic [ROB_SIZE-1:0] done,
  input  logic [ROB_SIZE-1:0] mispredict,
  output logic [CNT_W-1:0]    retire_count,
  output logic                mispredict_found,
  output logic [LANE_W-1:0]   mispredict_lane,
  output logic [ROB_SIZE-1:0] retire_mask,
  output logic [ROB_SIZE-1:0] squash
);

  logic       stop;
  rob_index_t idx;

  always_comb begin
    retire_count     = '0;
    mispredict_found = 1'b0;
    mispredict_lane  = '0;
    retire_mask      = '0;
    stop             = 1'b0;
    idx              = head;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      idx = rob_add(head, i);
      if (!stop && valid[idx] && done[idx]) begin
        retire_count     = CNT_W'(i + 1);
        retire_mask[idx] = 1'b1;
        if (mispredict[idx]) begin
          mispredict_found = 1'b1;
          mispredict_lane  = LANE_W'(i);
          stop             = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
    // Everything still valid and not retiring is younger than the branch
    squash = mispredict_found ? (valid & ~retire_mask) : '0;
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer; completion to retire output is two cycles, bundle held while out_ready is low.
// Mispredicted branches trigger recovery at their retirement, squashing all younger entries.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  micro_op_t  [RENAME_WIDTH-1:0]      uop_in,
  output rob_index_t                         alloc_index,
  input  logic       [COMPLETE_WIDTH-1:0]    complete_valid,
  input  rob_index_t [COMPLETE_WIDTH-1:0]    complete_index,
  input  logic       [COMPLETE_WIDTH-1:0]    complete_mispredict,
  output logic                               out_valid,
  input  logic                               out_ready,
  output micro_op_t  [COMMIT_WIDTH-1:0]      uop_retire,
  output logic                               recover,
  output micro_op_t                          uop_recover,
  output logic       [ARF_INT_SIZE-1:0]      arf_recover,
  output logic       [PRF_INT_SIZE-1:0]      prf_recover
);

  rob_state_t state;
  rob_ptr_t   head, tail, count, n_alloc, new_head;
  logic [ROB_SIZE-1:0] ent_valid, ent_done, ent_mispredict;
  logic [ROB_SIZE-1:0] valid_next, done_next, mp_next;
  logic [ROB_SIZE-1:0] retire_mask, squash;
  micro_op_t entries [ROB_SIZE];
  micro_op_t [RENAME_WIDTH-1:0] alloc_uop;
  micro_op_t [COMMIT_WIDTH-1:0] retire_next;
  logic [CNT_W-1:0]  retire_count;
  logic [LANE_W-1:0] mp_lane;
  logic              mp_found;
  logic sel_en, retire_fire, recover_fire, alloc_fire;
  logic [ARF_INT_SIZE-1:0] arf_next;
  logic [PRF_INT_SIZE-1:0] prf_next;

  assign count        = tail - head;
  assign alloc_index  = tail[ROB_INDEX_SIZE-1:0];
  assign in_ready     = (state == ROB_NORMAL) &&
                        ((rob_ptr_t'(ROB_SIZE) - count) >= rob_ptr_t'(RENAME_WIDTH));
  assign alloc_fire   = in_valid && in_ready;
  assign sel_en       = (state == ROB_NORMAL) && (!out_valid || out_ready);
  assign retire_fire  = sel_en && (retire_count != '0);
  assign recover_fire = retire_fire && mp_found;
  assign new_head     = head + rob_ptr_t'(retire_count);

  rob_retire_select u_select (
    .head             (head[ROB_INDEX_SIZE-1:0]),
    .valid            (ent_valid),
    .done             (ent_done),
    .mispredict       (ent_mispredict),
    .retire_count     (retire_count),
    .mispredict_found (mp_found),
    .mispredict_lane  (mp_lane),
    .retire_mask      (retire_mask),
    .squash           (squash)
  );

  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      n_alloc = n_alloc + rob_ptr_t'(uop_in[i].valid);
      alloc_uop[i] = uop_in[i];
      alloc_uop[i].rob_index = rob_add(alloc_index, i);
    end
  end

  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++)
      retire_next[i] = (CNT_W'(i) < retire_count) ?
                       entries[rob_add(head[ROB_INDEX_SIZE-1:0], i)] : '0;
  end

  // Squash masks include a group being allocated on the recovery edge
  always_comb begin
    arf_next = '0;
    prf_next = '0;
    for (int e = 0; e < ROB_SIZE; e++) begin
      if (squash[e] && entries[e].rd_valid) begin
        arf_next[entries[e].rd_arf_int_index] = 1'b1;
        prf_next[entries[e].rd_prf_int_index] = 1'b1;
      end
    end
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (alloc_fire && uop_in[i].valid && uop_in[i].rd_valid) begin
        arf_next[uop_in[i].rd_arf_int_index] = 1'b1;
        prf_next[uop_in[i].rd_prf_int_index] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_next = ent_valid;
    done_next  = ent_done;
    mp_next    = ent_mispredict;
    if (state == ROB_NORMAL) begin
      for (int j = 0; j < COMPLETE_WIDTH; j++) begin
        if (complete_valid[j] && ent_valid[complete_index[j]]) begin
          done_next[complete_index[j]] = 1'b1;
          mp_next[complete_index[j]]   = complete_mispredict[j];
        end
      end
    end
    if (retire_fire)
      valid_next = valid_next & ~(retire_mask | squash);
    if (alloc_fire && !recover_fire) begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (uop_in[i].valid) begin
          valid_next[rob_add(alloc_index, i)] = 1'b1;
          done_next[rob_add(alloc_index, i)]  = 1'b0;
          mp_next[rob_add(alloc_index, i)]    = 1'b0;
        end
      end
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset
  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      for (int i = 0; i < RENAME_WIDTH; i++)
        if (uop_in[i].valid)
          entries[rob_add(alloc_index, i)] <= alloc_uop[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ROB_NORMAL;
      head           <= '0;
      tail           <= '0;
      ent_valid      <= '0;
      ent_done       <= '0;
      ent_mispredict <= '0;
      out_valid      <= 1'b0;
      recover        <= 1'b0;
      uop_retire     <= '0;
      uop_recover    <= '0;
      arf_recover    <= '0;
      prf_recover    <= '0;
    end else begin
      ent_valid      <= valid_next;
      ent_done       <= done_next;
      ent_mispredict <= mp_next;
      if (retire_fire)
        head <= new_head;
      if (recover_fire)
        tail <= new_head;
      else if (alloc_fire)
        tail <= tail + n_alloc;

      if (state == ROB_RECOVER) begin
        if (out_ready) begin
          state       <= ROB_NORMAL;
          recover     <= 1'b0;
          out_valid   <= 1'b0;
          uop_retire  <= '0;
          arf_recover <= '0;
          prf_recover <= '0;
        end
      end else if (sel_en) begin
        out_valid  <= retire_fire;
        uop_retire <= retire_next;
        if (recover_fire) begin
          state       <= ROB_RECOVER;
          recover     <= 1'b1;
          uop_recover <= retire_next[mp_lane];
          arf_recover <= arf_next;
          prf_recover <= prf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order retire, out-of-order completion, recovery, full/wrap and reset.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clock, reset, in_valid, in_ready, out_valid, out_ready, recover;
  micro_op_t  [RENAME_WIDTH-1:0]   uop_in;
  rob_index_t                      alloc_index;
  logic       [COMPLETE_WIDTH-1:0] complete_valid, complete_mispredict;
  rob_index_t [COMPLETE_WIDTH-1:0] complete_index;
  micro_op_t  [COMMIT_WIDTH-1:0]   uop_retire;
  micro_op_t                       uop_recover;
  logic [ARF_INT_SIZE-1:0]         arf_recover;
  logic [PRF_INT_SIZE-1:0]         prf_recover;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .uop_in(uop_in), .alloc_index(alloc_index), .complete_valid(complete_valid),
    .complete_index(complete_index), .complete_mispredict(complete_mispredict),
    .out_valid(out_valid), .out_ready(out_ready), .uop_retire(uop_retire),
    .recover(recover), .uop_recover(uop_recover), .arf_recover(arf_recover),
    .prf_recover(prf_recover)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic micro_op_t mk(input logic rdv, input int arf, input int prf,
                                   input int prev, input logic br, input int cp);
    micro_op_t u;
    u = '0;
    u.valid                 = 1'b1;
    u.rd_valid              = rdv;
    u.rd_arf_int_index      = 5'(arf);
    u.rd_prf_int_index      = 6'(prf);
    u.rd_prev_prf_int_index = 6'(prev);
    u.is_branch             = br;
    u.cp_index              = 3'(cp);
    return u;
  endfunction

  function automatic micro_op_t mkf(input int idx);
    return mk(1'b1, idx % 32, idx % 64, 0, 1'b0, 0);
  endfunction

  task automatic dispatch(input micro_op_t u0, input micro_op_t u1,
                          input micro_op_t u2, input micro_op_t u3);
    in_valid = 1'b1;
    uop_in   = {u3, u2, u1, u0};
    step();
    in_valid = 1'b0;
    uop_in   = '0;
  endtask

  task automatic complete(input int n, input int i0, input int i1, input int i2,
                          input int i3, input logic [3:0] mp);
    int idx[4];
    idx = '{i0, i1, i2, i3};
    for (int k = 0; k < 4; k++) begin
      complete_valid[k] = (k < n);
      complete_index[k] = rob_index_t'(idx[k]);
    end
    complete_mispredict = mp;
    step();
    complete_valid      = '0;
    complete_mispredict = '0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; uop_in = '0; out_ready = 1'b1;
    complete_valid = '0; complete_index = '0; complete_mispredict = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_recover", recover, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alloc_index", alloc_index, 0);
    chk("rst_arf_recover", arf_recover, 0);
    chk("rst_prf_recover", prf_recover, 0);

    // Four uops, completed together, retire two cycles after the completion strobe
    dispatch(mk(1, 1, 33, 1, 0, 0), mk(1, 2, 34, 2, 0, 0), mk(1, 3, 35, 3, 0, 0), mk(1, 4, 36, 4, 0, 0));
    chk("t1_alloc_index", alloc_index, 4);
    complete(4, 0, 1, 2, 3, 4'b0000);
    chk("t1_not_yet", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_lane_valid", uop_retire[k].valid, 1);
      chk("t1_lane_rob", uop_retire[k].rob_index, k);
      chk("t1_lane_prd", uop_retire[k].rd_prf_int_index, 33 + k);
      chk("t1_lane_prev", uop_retire[k].rd_prev_prf_int_index, 1 + k);
    end
    step();
    chk("t1_out_drop", out_valid, 0);

    // Out-of-order completion: nothing retires until the head is done
    dispatch(mk(1, 7, 42, 0, 0, 0), mk(1, 8, 43, 0, 0, 0), mk(1, 9, 44, 0, 0, 0), mk(1, 10, 45, 0, 0, 0));
    complete(2, 6, 7, 0, 0, 4'b0000);
    step();
    chk("t2_blocked", out_valid, 0);
    complete(2, 4, 5, 0, 0, 4'b0000);
    chk("t2_blocked2", out_valid, 0);
    step();
    chk("t2_out_valid", out_valid, 1);
    chk("t2_lane0_rob", uop_retire[0].rob_index, 4);
    chk("t2_lane2_arf", uop_retire[2].rd_arf_int_index, 9);
    chk("t2_lane3_prd", uop_retire[3].rd_prf_int_index, 45);
    step();

    // Mispredicted branch at 9 with younger 10..11 plus a group allocated on the recovery edge
    dispatch(mk(1, 8, 48, 0, 0, 0), mk(0, 0, 0, 0, 1, 3), mk(1, 5, 40, 0, 0, 0), mk(1, 6, 41, 0, 0, 0));
    complete(3, 8, 9, 10, 0, 4'b0010);
    chk("t3_in_ready", in_ready, 1);
    in_valid = 1'b1;
    uop_in   = {micro_op_t'('0), micro_op_t'('0), mk(0, 13, 51, 0, 0, 0), mk(1, 12, 50, 0, 0, 0)};
    step();
    in_valid  = 1'b0;
    uop_in    = '0;
    out_ready = 1'b0;
    chk("t3_out_valid", out_valid, 1);
    chk("t3_recover", recover, 1);
    chk("t3_recover_cp", uop_recover.cp_index, 3);
    chk("t3_recover_rob", uop_recover.rob_index, 9);
    chk("t3_lane0_rob", uop_retire[0].rob_index, 8);
    chk("t3_lane1_branch", uop_retire[1].is_branch, 1);
    chk("t3_lane2_invalid", uop_retire[2].valid, 0);
    chk("t3_arf_mask", arf_recover, 64'h0000_1060);
    chk("t3_prf_mask", prf_recover, 64'h0004_0300_0000_0000);
    chk("t3_tail_eq_head", alloc_index, 10);
    chk("t3_in_ready_rec", in_ready, 0);

    // Recovery held while the rename stage stalls
    for (int c = 0; c < 3; c++) begin
      complete_valid = 4'b0001; complete_index[0] = 10; complete_mispredict = 4'b0001;
      step();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_recover", recover, 1);
      chk("t4_hold_in_ready", in_ready, 0);
      chk("t4_hold_prf", prf_recover, 64'h0004_0300_0000_0000);
    end
    complete_valid = '0; complete_mispredict = '0;
    out_ready = 1'b1;
    step();
    chk("t4_rel_recover", recover, 0);
    chk("t4_rel_out_valid", out_valid, 0);
    chk("t4_rel_in_ready", in_ready, 1);

    // Fill to full starting at 10, wrapping past 63
    for (int g = 0; g < 16; g++) begin
      int b;
      b = 10 + 4 * g;
      chk("t5_fill_ready", in_ready, 1);
      chk("t5_fill_alloc", alloc_index, b % 64);
      dispatch(mkf(b), mkf(b + 1), mkf(b + 2), mkf(b + 3));
    end
    chk("t5_full_ready", in_ready, 0);
    chk("t5_full_alloc", alloc_index, 10);
    complete(4, 10, 11, 12, 13, 4'b0000);
    chk("t5_still_full", in_ready, 0);
    step();
    chk("t5_first_valid", out_valid, 1);
    chk("t5_first_rob", uop_retire[0].rob_index, 10);
    chk("t5_first_prd", uop_retire[3].rd_prf_int_index, 13);
    chk("t5_space_ready", in_ready, 1);
    for (int g = 1; g < 16; g++) begin
      int b;
      int p;
      b = 10 + 4 * g;
      p = b - 4;
      complete(4, b % 64, (b + 1) % 64, (b + 2) % 64, (b + 3) % 64, 4'b0000);
      if (g == 1) chk("t5_stream_gap", out_valid, 0);
      else begin
        chk("t5_stream_valid", out_valid, 1);
        chk("t5_stream_rob", uop_retire[0].rob_index, p % 64);
        chk("t5_stream_prd", uop_retire[2].rd_prf_int_index, (p + 2) % 64);
      end
    end
    step();
    chk("t5_last_valid", out_valid, 1);
    chk("t5_last_rob", uop_retire[0].rob_index, 6);
    chk("t5_last_prd", uop_retire[3].rd_prf_int_index, 9);
    step();
    chk("t5_empty_valid", out_valid, 0);

    // Reset with 20 entries outstanding
    for (int g = 0; g < 5; g++) begin
      int b;
      b = 10 + 4 * g;
      dispatch(mkf(b), mkf(b + 1), mkf(b + 2), mkf(b + 3));
    end
    complete(4, 10, 11, 12, 13, 4'b0000);
    step();
    out_ready = 1'b0;
    chk("t6_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_lane", uop_retire[0].valid, 0);
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("t6_rel_ready", in_ready, 1);
    chk("t6_rel_alloc", alloc_index, 0);
    chk("t6_rel_valid", out_valid, 0);
    dispatch(mk(1, 20, 60, 0, 0, 0), mk(1, 21, 61, 0, 0, 0), mk(1, 22, 62, 0, 0, 0), mk(1, 23, 63, 0, 0, 0));
    chk("t6_alloc_after", alloc_index, 4);
    complete(4, 0, 1, 2, 3, 4'b0000);
    step();
    chk("t6_out_valid", out_valid, 1);
    chk("t6_lane0_rob", uop_retire[0].rob_index, 0);
    chk("t6_lane1_arf", uop_retire[1].rd_arf_int_index, 21);
    chk("t6_lane3_prd", uop_retire[3].rd_prf_int_index, 63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
